arbitro_rr4: RTL and testbench



---
 rtl/arbitro_rr4_pkg.sv | 39 +++
 rtl/arbitro_rr4_if.sv | 33 +++
 rtl/arbitro_rr4_decod24_en.sv | 18 +
 rtl/arbitro_rr4.sv | 106 ++++++++++
 tb/tb_arbitro_rr4.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/arbitro_rr4_pkg.sv
// arb_pkg: shared types, constants and the circular priority search used by
// the four-requester round-robin arbiter.
//   state_t   : arbiter FSM states (IDLE, GRANT, RELEASE)
//   N_REQ     : number of requesters
//   IDX_W     : width of a requester index
//   next_idx  : first set request bit searching ptr, ptr+1, ptr+2, ptr+3 (mod 4)
package arb_pkg;

    localparam int N_REQ = 4;
    localparam int IDX_W = 2;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        RELEASE
    } state_t;

    // Returns ptr itself when no bit is set; callers only use the result when
    // at least one request is pending.
    function automatic logic [IDX_W-1:0] next_idx(
        input logic [IDX_W-1:0] ptr,
        input logic [N_REQ-1:0] req
    );
        logic [IDX_W-1:0] result;
        logic [IDX_W-1:0] cand;
        logic             found;
        result = ptr;
        found  = 1'b0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            cand = ptr + IDX_W'(i);
            if (!found && req[cand]) begin
                result = cand;
                found  = 1'b1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/arbitro_rr4_if.sv
// arbitro_rr4_if: request/grant bundle between the requesters and the arbiter.
//   req       : request vector, bit i held high while requester i wants/uses the slot
//   gnt       : one-hot grant (all zero when nobody owns the slot)
//   gnt_idx   : index of the current or last owner
//   gnt_valid : a grant is active
//   preempt   : one-cycle pulse when the hold limit revokes a grant
// Modports: master = requester side, slave = arbiter side.
interface arbitro_rr4_if;
    import arb_pkg::*;

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] gnt;
    logic [IDX_W-1:0] gnt_idx;
    logic             gnt_valid;
    logic             preempt;

    modport master (
        output req,
        input  gnt,
        input  gnt_idx,
        input  gnt_valid,
        input  preempt
    );

    modport slave (
        input  req,
        output gnt,
        output gnt_idx,
        output gnt_valid,
        output preempt
    );

endinterface

// File: rtl/arbitro_rr4_decod24_en.sv
// decod24_en: plain 2-to-4 decoder with enable.
//   idx : index to decode
//   en  : when low, all outputs are zero
//   y   : one-hot output (y[idx] = en)
module decod24_en (
    input  logic [1:0] idx,
    input  logic       en,
    output logic [3:0] y
);

    always_comb begin
        y = '0;
        if (en) begin
            y[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/arbitro_rr4.sv
// arbitro_rr4: four-requester round-robin arbiter with optional hold limit.
// The winner index and valid flag are registered; the one-hot grant is decoded
// from them. Each release is followed by exactly one dead cycle before the
// next arbitration, and the priority pointer moves past the released owner.
// Parameters:
//   MAX_HOLD : consecutive grant cycles before a forced rotation when others
//              are waiting; 0 disables the limit
//   CNT_W    : hold counter width, 2**CNT_W must exceed MAX_HOLD
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : arbitro_rr4_if.slave (req in; gnt, gnt_idx, gnt_valid, preempt out)
module arbitro_rr4
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    arbitro_rr4_if.slave  bus
);

    localparam logic [CNT_W-1:0] HOLD_SAT  = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

    state_t           state;
    logic [IDX_W-1:0] gnt_idx;
    logic             gnt_valid;
    logic             preempt;
    logic [IDX_W-1:0] ptr;
    logic [CNT_W-1:0] hold_cnt;

    logic [N_REQ-1:0] gnt_dec;
    logic             own_req;
    logic             others_waiting;
    logic             limit_hit;

    decod24_en u_dec (
        .idx (gnt_idx),
        .en  (gnt_valid),
        .y   (gnt_dec)
    );

    // In GRANT, gnt_dec is exactly the owner's bit, so masking it out of req
    // leaves only the competing requesters.
    always_comb begin
        own_req        = bus.req[gnt_idx];
        others_waiting = |(bus.req & ~gnt_dec);
        // >= rather than == so that once the counter has saturated, a late
        // arriving requester preempts on its first sampled cycle.
        limit_hit      = (MAX_HOLD != 0) && (hold_cnt >= HOLD_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
            preempt   <= 1'b0;
            ptr       <= '0;
            hold_cnt  <= '0;
        end else begin
            preempt <= 1'b0;
            case (state)
                IDLE: begin
                    if (|bus.req) begin
                        gnt_idx   <= next_idx(ptr, bus.req);
                        gnt_valid <= 1'b1;
                        hold_cnt  <= '0;
                        state     <= GRANT;
                    end
                end
                GRANT: begin
                    if (hold_cnt != HOLD_SAT) begin
                        hold_cnt <= hold_cnt + CNT_W'(1);
                    end
                    // Normal release is tested first so it wins over the
                    // hold limit and never produces a preempt pulse.
                    if (!own_req) begin
                        gnt_valid <= 1'b0;
                        ptr       <= gnt_idx + IDX_W'(1);
                        state     <= RELEASE;
                    end else if (limit_hit && others_waiting) begin
                        preempt   <= 1'b1;
                        gnt_valid <= 1'b0;
                        ptr       <= gnt_idx + IDX_W'(1);
                        state     <= RELEASE;
                    end
                end
                RELEASE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.gnt       = gnt_dec;
    assign bus.gnt_idx   = gnt_idx;
    assign bus.gnt_valid = gnt_valid;
    assign bus.preempt   = preempt;

endmodule

// File: tb/tb_arbitro_rr4.sv
module tb_arbitro_rr4;
    import arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int unsigned errors = 0;
    int unsigned checks = 0;

    // Scoreboard entries: {gnt[3:0], preempt} expected one clock after the
    // request vector is applied.
    logic [4:0] sb_q[$];

    arbitro_rr4_if bus ();
    arbitro_rr4_if bus0 ();

    arbitro_rr4 #(.MAX_HOLD(8), .CNT_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    arbitro_rr4 #(.MAX_HOLD(0), .CNT_W(4)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0.slave)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            if ($countones(bus.gnt) > 1 || $countones(bus0.gnt) > 1) begin
                errors++;
                $display("FAIL onehot: gnt=%b gnt0=%b required at most one bit", bus.gnt, bus0.gnt);
            end
        end
    end

    task automatic do_reset;
        rst_n    = 1'b0;
        bus.req  = '0;
        bus0.req = '0;
        sb_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        logic [4:0] got, exp_v;
        logic [8:0] tbl [5] = '{
            9'b0100_0100_0, 9'b0100_0100_0,
            9'b0001_0001_0, 9'b0000_0000_0, 9'b0000_0000_0
        };
        rst_n   = 1'b0;
        bus.req = '0;
        #2;
        checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b required 0000", bus.gnt); end
        checks++; if (bus.gnt_idx !== 2'b00) begin errors++; $display("FAIL reset_idx: got %b required 00", bus.gnt_idx); end
        checks++; if (bus.gnt_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b required 0", bus.gnt_valid); end
        checks++; if (bus.preempt !== 1'b0) begin errors++; $display("FAIL reset_preempt: got %b required 0", bus.preempt); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            bus.req = tbl[i][8:5];
            sb_q.push_back(tbl[i][4:0]);
            @(negedge clk);
            got = {bus.gnt, bus.preempt};
            exp_v = sb_q.pop_front();
            checks++;
            if (got !== exp_v) begin errors++; $display("FAIL reset_grant[%0d]: gnt/preempt %b/%b required %b/%b", i, got[4:1], got[0], exp_v[4:1], exp_v[0]); end
        end
        // Asynchronous reset mid-cycle, well away from any clock edge.
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL midreset_gnt: got %b required 0000", bus.gnt); end
        checks++; if (bus.gnt_valid !== 1'b0) begin errors++; $display("FAIL midreset_valid: got %b required 0", bus.gnt_valid); end
        checks++; if (bus.gnt_idx !== 2'b00) begin errors++; $display("FAIL midreset_idx: got %b required 00", bus.gnt_idx); end
        checks++; if (dut.ptr !== 2'b00) begin errors++; $display("FAIL midreset_ptr: got %b required 00", dut.ptr); end
        bus.req = 4'b0001;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 2; i < 5; i++) begin
            bus.req = tbl[i][8:5];
            sb_q.push_back(tbl[i][4:0]);
            @(negedge clk);
            got = {bus.gnt, bus.preempt};
            exp_v = sb_q.pop_front();
            checks++;
            if (got !== exp_v) begin errors++; $display("FAIL reset_after[%0d]: gnt/preempt %b/%b required %b/%b", i, got[4:1], got[0], exp_v[4:1], exp_v[0]); end
        end
    endtask

    task automatic test_single;
        logic [4:0] got, exp_v;
        logic [3:0] r;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            r = (i < 5) ? 4'b0010 : 4'b0000;
            bus.req = r;
            sb_q.push_back((i < 5) ? 5'b0010_0 : 5'b0000_0);
            @(negedge clk);
            got = {bus.gnt, bus.preempt};
            exp_v = sb_q.pop_front();
            checks++;
            if (got !== exp_v) begin errors++; $display("FAIL single[%0d]: gnt/preempt %b/%b required %b/%b", i, got[4:1], got[0], exp_v[4:1], exp_v[0]); end
        end
        checks++; if (dut.ptr !== 2'd2) begin errors++; $display("FAIL single_ptr: got %0d required 2", dut.ptr); end
        checks++; if (bus.gnt_idx !== 2'd1) begin errors++; $display("FAIL single_idx_held: got %0d required 1", bus.gnt_idx); end
        checks++; if (bus.gnt_valid !== 1'b0) begin errors++; $display("FAIL single_valid: got %b required 0", bus.gnt_valid); end
    endtask

    task automatic test_round_robin;
        logic [4:0] got, exp_v;
        logic [3:0] oh, r, eg;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            oh = 4'b0001 << (k % 4);
            for (int j = 0; j < 4; j++) begin
                r  = (j == 2) ? (4'b1111 & ~oh) : 4'b1111;
                eg = (j < 2) ? oh : 4'b0000;
                bus.req = r;
                sb_q.push_back({eg, 1'b0});
                @(negedge clk);
                got = {bus.gnt, bus.preempt};
                exp_v = sb_q.pop_front();
                checks++;
                if (got !== exp_v) begin errors++; $display("FAIL round_robin[%0d.%0d]: gnt/preempt %b/%b required %b/%b", k, j, got[4:1], got[0], exp_v[4:1], exp_v[0]); end
            end
        end
    endtask

    task automatic test_hold_limit;
        logic [4:0] got, exp_v;
        logic [8:0] tbl [13] = '{
            9'b0001_0001_0, 9'b0001_0001_0, 9'b0001_0001_0,
            9'b0101_0001_0, 9'b0101_0001_0, 9'b0101_0001_0, 9'b0101_0001_0, 9'b0101_0001_0,
            9'b0101_0000_1, 9'b0101_0000_0, 9'b0101_0100_0,
            9'b0000_0000_0, 9'b0000_0000_0
        };
        do_reset();
        for (int i = 0; i < 13; i++) begin
            bus.req = tbl[i][8:5];
            sb_q.push_back(tbl[i][4:0]);
            @(negedge clk);
            got = {bus.gnt, bus.preempt};
            exp_v = sb_q.pop_front();
            checks++;
            if (got !== exp_v) begin errors++; $display("FAIL hold_limit[%0d]: gnt/preempt %b/%b required %b/%b", i, got[4:1], got[0], exp_v[4:1], exp_v[0]); end
        end
        checks++; if (dut.ptr !== 2'd3) begin errors++; $display("FAIL hold_limit_ptr: got %0d required 3", dut.ptr); end
    endtask

    task automatic test_release_priority;
        logic [4:0] got, exp_v;
        logic [8:0] tbl [13] = '{
            9'b0001_0001_0, 9'b0001_0001_0, 9'b0001_0001_0, 9'b0001_0001_0,
            9'b0001_0001_0, 9'b0001_0001_0, 9'b0001_0001_0,
            9'b0011_0001_0, 9'b0010_0000_0, 9'b0010_0000_0, 9'b0010_0010_0,
            9'b0000_0000_0, 9'b0000_0000_0
        };
        do_reset();
        for (int i = 0; i < 13; i++) begin
            bus.req = tbl[i][8:5];
            sb_q.push_back(tbl[i][4:0]);
            @(negedge clk);
            got = {bus.gnt, bus.preempt};
            exp_v = sb_q.pop_front();
            checks++;
            if (got !== exp_v) begin errors++; $display("FAIL release_priority[%0d]: gnt/preempt %b/%b required %b/%b", i, got[4:1], got[0], exp_v[4:1], exp_v[0]); end
        end
    endtask

    task automatic test_lone_holder;
        logic [4:0] got, exp_v;
        logic [8:0] tail [5] = '{
            9'b0011_0000_1, 9'b0011_0000_0, 9'b0011_0001_0,
            9'b0000_0000_0, 9'b0000_0000_0
        };
        do_reset();
        for (int i = 0; i < 20; i++) begin
            bus.req = 4'b0010;
            sb_q.push_back(5'b0010_0);
            @(negedge clk);
            got = {bus.gnt, bus.preempt};
            exp_v = sb_q.pop_front();
            checks++;
            if (got !== exp_v) begin errors++; $display("FAIL lone[%0d]: gnt/preempt %b/%b required %b/%b", i, got[4:1], got[0], exp_v[4:1], exp_v[0]); end
        end
        checks++; if (dut.hold_cnt !== 4'd8) begin errors++; $display("FAIL lone_hold_sat: got %0d required 8", dut.hold_cnt); end
        // A late arrival after saturation preempts at once; search from ptr=2 wraps to 0.
        for (int i = 0; i < 5; i++) begin
            bus.req = tail[i][8:5];
            sb_q.push_back(tail[i][4:0]);
            @(negedge clk);
            got = {bus.gnt, bus.preempt};
            exp_v = sb_q.pop_front();
            checks++;
            if (got !== exp_v) begin errors++; $display("FAIL lone_late[%0d]: gnt/preempt %b/%b required %b/%b", i, got[4:1], got[0], exp_v[4:1], exp_v[0]); end
        end
    endtask

    task automatic test_wrap;
        logic [4:0] got, exp_v;
        logic [8:0] tbl [5] = '{
            9'b1000_1000_0, 9'b1011_1000_0, 9'b0011_0000_0,
            9'b0011_0000_0, 9'b0011_0001_0
        };
        do_reset();
        for (int i = 0; i < 5; i++) begin
            bus.req = tbl[i][8:5];
            sb_q.push_back(tbl[i][4:0]);
            @(negedge clk);
            got = {bus.gnt, bus.preempt};
            exp_v = sb_q.pop_front();
            checks++;
            if (got !== exp_v) begin errors++; $display("FAIL wrap[%0d]: gnt/preempt %b/%b required %b/%b", i, got[4:1], got[0], exp_v[4:1], exp_v[0]); end
        end
        checks++; if (dut.ptr !== 2'd0) begin errors++; $display("FAIL wrap_ptr: got %0d required 0", dut.ptr); end
        checks++; if (bus.gnt_idx !== 2'd0) begin errors++; $display("FAIL wrap_idx: got %0d required 0", bus.gnt_idx); end
    endtask

    task automatic test_no_limit;
        logic [4:0] got, exp_v;
        logic [3:0] r, eg;
        do_reset();
        for (int i = 0; i < 18; i++) begin
            r  = (i == 0) ? 4'b0001 : (i < 15) ? 4'b0101 : 4'b0100;
            eg = (i < 15) ? 4'b0001 : (i < 17) ? 4'b0000 : 4'b0100;
            bus0.req = r;
            sb_q.push_back({eg, 1'b0});
            @(negedge clk);
            got = {bus0.gnt, bus0.preempt};
            exp_v = sb_q.pop_front();
            checks++;
            if (got !== exp_v) begin errors++; $display("FAIL no_limit[%0d]: gnt/preempt %b/%b required %b/%b", i, got[4:1], got[0], exp_v[4:1], exp_v[0]); end
        end
    endtask

    initial begin
        bus.req  = '0;
        bus0.req = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_hold_limit();
        test_release_priority();
        test_lone_holder();
        test_wrap();
        test_no_limit();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
